// File: rtl/nios_system_button_pkg.sv
// nios_system_button_pkg
// Shared constants for the push-button controller: the Avalon register
// word addresses and the encodings of the EDGE_TYPE parameter.
// No ports; imported by button_debounce_bit and nios_system_button_ctrl.
package nios_system_button_pkg;

    // Register word addresses on the s1 slave
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    // Which debounced transition counts as an event
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/button_debounce_bit.sv
// button_debounce_bit
// One button lane: two-flop synchronizer, stability counter, debounced
// level flop and a filtered one-cycle edge pulse.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   raw        in   raw asynchronous button input
//   sync       out  second synchronizer stage
//   deb        out  debounced level
//   edge_pulse out  high during the cycle in which deb takes its new value,
//                   if that transition matches EDGE_TYPE
module button_debounce_bit
    import nios_system_button_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_W           = 16,
    parameter logic IDLE_BIT        = 1'b1,
    parameter int   EDGE_TYPE       = EDGE_FALL
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic sync,
    output logic deb,
    output logic edge_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // Both synchronizer stages reset to the released level so that reset
    // release never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= IDLE_BIT;
            sync <= IDLE_BIT;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // The new level is accepted on the cycle the counter has already seen
    // DEBOUNCE_CYCLES-1 mismatches and the current sample still disagrees,
    // i.e. after DEBOUNCE_CYCLES consecutive disagreeing samples.
    assign accept = (sync != deb) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            deb <= IDLE_BIT;
        end else if (sync == deb) begin
            cnt <= '0;
        end else if (accept) begin
            deb <= sync;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // The pulse coincides with the accept cycle, so the capture register
    // in the top level sets on the same clock edge that deb changes.
    always_comb begin
        edge_pulse = 1'b0;
        if (accept) begin
            case (EDGE_TYPE)
                EDGE_RISE: edge_pulse = sync;
                EDGE_FALL: edge_pulse = ~sync;
                default:   edge_pulse = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/nios_system_button_ctrl.sv
// nios_system_button_ctrl
// Avalon-MM slave for the board push-buttons: debounces each input,
// latches sticky edge flags and drives a maskable level interrupt.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   word address (0 deb, 1 irq_mask, 2 edge_capture, 3 sync)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data, bits [WIDTH-1:0] used
//   in_port     in   raw button inputs
//   readdata    out  registered read data, upper bits zero
//   irq         out  |(edge_capture & irq_mask)
module nios_system_button_ctrl
    import nios_system_button_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               CNT_W           = 16,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = 8'hFF,
    parameter int               EDGE_TYPE       = EDGE_FALL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] clear_bits;
    logic [WIDTH-1:0] read_mux;
    logic             wr;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata are meaningful.
    assign unused_wdata = ^writedata[31:WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        button_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .IDLE_BIT        (IDLE_LEVEL[i]),
            .EDGE_TYPE       (EDGE_TYPE)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .raw        (in_port[i]),
            .sync       (sync_q[i]),
            .deb        (deb[i]),
            .edge_pulse (edge_pulse[i])
        );
    end

    assign wr         = chipselect & ~write_n;
    assign clear_bits = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA: read_mux = deb;
            ADDR_MASK: read_mux = irq_mask;
            ADDR_EDGE: read_mux = edge_capture;
            ADDR_RAW:  read_mux = sync_q;
            default:   read_mux = '0;
        endcase
    end

    // Read data is refreshed every cycle regardless of chipselect.
    // The edge pulse is OR-ed in after the clear so a press arriving in the
    // same cycle as a write-1-to-clear is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata     <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            readdata <= {{(32 - WIDTH){1'b0}}, read_mux};
            if (wr && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_capture <= (edge_capture & ~clear_bits) | edge_pulse;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_system_button_ctrl.sv
// tb_nios_system_button_ctrl
// Directed bench for nios_system_button_ctrl with DEBOUNCE_CYCLES=4,
// falling-edge capture and idle level 8'hFF. A behavioural model predicts
// readdata and irq every cycle; literal checks pin the key timings.
module tb_nios_system_button_ctrl;
    import nios_system_button_pkg::*;

    localparam int         WIDTH = 8;
    localparam int         DEB   = 4;
    localparam logic [7:0] IDLE  = 8'hFF;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    nios_system_button_ctrl #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (16),
        .IDLE_LEVEL      (IDLE),
        .EDGE_TYPE       (EDGE_FALL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a level is accepted once the last DEB synchronized
    // samples all disagree with the current debounced level.
    logic [7:0]     m_sync1, m_sync2, m_deb, m_mask, m_cap;
    logic [31:0]    m_rd;
    logic [DEB-1:0] m_win [WIDTH];
    logic [7:0]     m_pulse, m_clr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_sync1 = IDLE;
            m_sync2 = IDLE;
            m_deb   = IDLE;
            m_mask  = 8'h00;
            m_cap   = 8'h00;
            m_rd    = 32'h0;
            for (int i = 0; i < WIDTH; i++) m_win[i] = {DEB{IDLE[i]}};
        end else begin
            case (address)
                2'd0:    m_rd = {24'h0, m_deb};
                2'd1:    m_rd = {24'h0, m_mask};
                2'd2:    m_rd = {24'h0, m_cap};
                default: m_rd = {24'h0, m_sync2};
            endcase
            m_pulse = 8'h00;
            for (int i = 0; i < WIDTH; i++) begin
                m_win[i] = {m_win[i][DEB-2:0], m_sync2[i]};
                if (m_win[i] == {DEB{~m_deb[i]}}) begin
                    m_deb[i] = ~m_deb[i];
                    if (m_deb[i] == 1'b0) m_pulse[i] = 1'b1;
                end
            end
            m_clr = 8'h00;
            if (chipselect && !write_n && address == 2'd2) m_clr = writedata[7:0];
            if (chipselect && !write_n && address == 2'd1) m_mask = writedata[7:0];
            m_cap   = (m_cap & ~m_clr) | m_pulse;
            m_sync2 = m_sync1;
            m_sync1 = in_port;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle: outputs must be zero during reset, otherwise match the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            check_output("reset_rd", readdata, 32'h0);
            check_output("reset_irq", {31'h0, irq}, 32'h0);
        end else begin
            check_output("model_rd", readdata, m_rd);
            check_output("model_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        address = a;
        @(negedge clk);
        v = readdata;
    endtask

    logic [31:0] v;

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hFF;
        repeat (3) @(negedge clk);
        check_output("lit_reset_rd", readdata, 32'h0);
        reset_n = 1'b1;

        // Reset values
        read_reg(ADDR_DATA, v); check_output("lit_data_idle", v, 32'hFF);
        read_reg(ADDR_MASK, v); check_output("lit_mask_reset", v, 32'h0);
        read_reg(ADDR_EDGE, v); check_output("lit_edge_reset", v, 32'h0);
        check_output("lit_irq_reset", {31'h0, irq}, 32'h0);

        // Press bit 0: deb updates on the 6th edge after the change
        address    = ADDR_DATA;
        in_port[0] = 1'b0;
        repeat (6) @(negedge clk);
        check_output("lit_deb_before_latency", readdata, 32'hFF);
        @(negedge clk);
        check_output("lit_deb_after_latency", readdata, 32'hFE);
        check_output("lit_irq_masked", {31'h0, irq}, 32'h0);
        read_reg(ADDR_EDGE, v); check_output("lit_edge_bit0", v, 32'h01);

        // Mask then W1C
        bus_write(ADDR_MASK, 32'h01);
        check_output("lit_irq_after_mask", {31'h0, irq}, 32'h1);
        bus_write(ADDR_EDGE, 32'h01);
        check_output("lit_irq_after_w1c", {31'h0, irq}, 32'h0);
        read_reg(ADDR_EDGE, v); check_output("lit_edge_cleared", v, 32'h0);

        // 3-cycle glitch on bit 3 is rejected
        in_port[3] = 1'b0;
        repeat (3) @(negedge clk);
        in_port[3] = 1'b1;
        repeat (10) @(negedge clk);
        read_reg(ADDR_DATA, v); check_output("lit_glitch_data", v, 32'hFE);
        read_reg(ADDR_EDGE, v); check_output("lit_glitch_edge", v, 32'h0);
        check_output("lit_glitch_irq", {31'h0, irq}, 32'h0);

        // 4-cycle low on bit 4 is just long enough to be accepted
        in_port[4] = 1'b0;
        repeat (4) @(negedge clk);
        in_port[4] = 1'b1;
        repeat (12) @(negedge clk);
        read_reg(ADDR_EDGE, v); check_output("lit_min_pulse_edge", v, 32'h10);
        read_reg(ADDR_DATA, v); check_output("lit_min_pulse_data", v, 32'hFE);
        bus_write(ADDR_EDGE, 32'h10);

        // Bit 5: press, clear, release (no capture), re-press with W1C colliding
        in_port[5] = 1'b0;
        repeat (10) @(negedge clk);
        read_reg(ADDR_EDGE, v); check_output("lit_press5", v, 32'h20);
        bus_write(ADDR_EDGE, 32'h20);
        in_port[5] = 1'b1;
        repeat (10) @(negedge clk);
        read_reg(ADDR_EDGE, v); check_output("lit_release5_nocap", v, 32'h0);
        in_port[5] = 1'b0;
        repeat (5) @(negedge clk);
        bus_write(ADDR_EDGE, 32'h20);
        read_reg(ADDR_EDGE, v); check_output("lit_set_wins", v, 32'h20);
        bus_write(ADDR_MASK, 32'h20);
        check_output("lit_irq_bit5", {31'h0, irq}, 32'h1);

        // Reset in the middle of a bit-2 count
        in_port[2] = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        in_port = 8'hFF;
        repeat (2) @(negedge clk);
        check_output("lit_midreset_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        read_reg(ADDR_DATA, v); check_output("lit_post_reset_data", v, 32'hFF);
        read_reg(ADDR_MASK, v); check_output("lit_post_reset_mask", v, 32'h0);
        read_reg(ADDR_EDGE, v); check_output("lit_post_reset_edge", v, 32'h0);
        read_reg(ADDR_RAW, v);  check_output("lit_post_reset_raw", v, 32'hFF);
        check_output("lit_post_reset_irq", {31'h0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
